comparador_bist: RTL and testbench
==================================

Name: comparador_bist

Overview:
- Built-in self-test sequencer for a WIDTH-bit equality comparator (sistema_y-style: inputs A, B; output Q=1 iff A==B).
- On start, drives every (A,B) pair exhaustively into the comparator, samples its Q, and checks Q against the expected A==B.
- Counts mismatches and reports pass/fail.
- Sits beside the comparator in the lab top level: stimulus end plus checking end of the same A/B/Q interface.

Parameters:
- WIDTH, 4, bit width of each comparator operand.
- SETTLE, 1, cycles each vector is held before Q is sampled; legal range is 1 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to run a test; honoured only in IDLE or DONE.
- A_out  output  WIDTH  operand A to comparator.
- B_out  output  WIDTH  operand B to comparator.
- q_in  input  1  comparator result Q.
- busy  output  1  high while a test runs.
- done  output  1  high in DONE until the next start.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  2*WIDTH+1  number of mismatching vectors.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, A_out=0, B_out=0, busy=0, done=0, pass=0, err_count=0, idx=0, settle counter=0.
- idx is a 2*WIDTH-bit vector index. A_out=idx[2*WIDTH-1:WIDTH], B_out=idx[WIDTH-1:0]. B therefore varies fastest, and the order is A=0..max, B=0..max.
- States: IDLE, APPLY, CHECK, DONE. All outputs are registered.
- IDLE: start=1 at an edge takes the FSM to APPLY. In the same edge: idx=0, err_count=0, busy=1, done=0, pass=0.
- APPLY: holds the current vector for SETTLE cycles (counter 0..SETTLE-1), then goes to CHECK.
- CHECK: one cycle. q_in is sampled at the end of this cycle. The expected value is (A_out==B_out), computed internally. On a mismatch, err_count increments.
  - If idx is all ones, go to DONE.
  - Otherwise idx increments and the FSM returns to APPLY; the counter clears.
- Per-vector time is SETTLE+1 cycles. A full run is 2^(2*WIDTH)*(SETTLE+1) cycles from the first APPLY cycle to DONE entry. With defaults this is 512.
- DONE: busy=0, done=1, pass=(err_count==0). A_out/B_out hold the last vector applied. err_count is held. start=1 restarts exactly as from IDLE.
- start while busy=1 is ignored, with no effect on idx or err_count.
- err_count saturates at 2^(2*WIDTH). It cannot overflow, because its width exceeds the vector count.
- rst_n low in any state, including mid-run, forces reset values immediately. No partial result is retained.
- q_in is treated as synchronous to clk; the comparator is combinational from A_out/B_out.

Optional Feature:
- Macro STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes straight to DONE with err_count=1. A_out/B_out and idx freeze on the failing vector, identifying it, and pass=0.
- Undefined: the run always completes all vectors and err_count holds the total number of mismatches.

Test Plan:
- Correct comparator model (Q=(A==B)), start pulse -> busy=1 for 512 cycles (defaults), then done=1, pass=1, err_count=0, A_out=4'hF, B_out=4'hF.
- Stuck-at-0 model (Q=0) -> done=1, pass=0, err_count=16.
- Inverted model (Q=(A!=B)) -> err_count=256, pass=0.
- Model wrong only at A=5,B=5 -> err_count=1.
  - With STOP_ON_FAIL_EN: DONE is entered after vector index 0x55, with A_out=5, B_out=5 and err_count=1.
- start held high or pulsed mid-run -> no restart and the same final counts. Start asserted in DONE -> a fresh run, with err_count cleared on the start edge.
- rst_n asserted at cycle 100 of a run, then released -> all outputs are at reset values and the FSM is in IDLE. A new start then completes normally with pass=1.

Source files
------------

// File: rtl/comparador_bist.sv
// comparador_bist: exhaustive built-in self-test sequencer for a WIDTH-bit equality comparator.
// Optional feature macro: STOP_ON_FAIL_EN (halt on the first mismatching vector).
`default_nettype none

module comparador_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     A_out,
  output logic [WIDTH-1:0]     B_out,
  input  logic                 q_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count
);

  localparam int IW = 2 * WIDTH;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IW:0]   ERR_MAX     = {1'b1, {IW{1'b0}}};
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [SW-1:0] cnt, cnt_n;
  logic [IW:0]   err_n, err_chk;
  logic          busy_n, done_n, pass_n;
  logic          expected, mismatch, finish;

  // Operands come straight from the registered vector index, so they are registered too.
  assign A_out = idx[IW-1:WIDTH];
  assign B_out = idx[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      err_count <= err_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    err_n    = err_count;
    busy_n   = busy;
    done_n   = done;
    pass_n   = pass;
    finish   = 1'b0;
    expected = (A_out == B_out);
    mismatch = (q_in != expected);
    err_chk  = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_chk = err_count + 1'b1;
    end

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = APPLY;
          idx_n   = '0;
          cnt_n   = '0;
          err_n   = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
        end
      end
      APPLY: begin
        if (cnt == SETTLE_LAST) begin
          state_n = CHECK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CHECK: begin
        err_n = err_chk;
`ifdef STOP_ON_FAIL_EN
        if (mismatch) begin
          finish = 1'b1;
        end
`endif
        if (&idx) begin
          finish = 1'b1;
        end
        if (finish) begin
          // idx is left on the last (or failing) vector so A_out/B_out identify it.
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_chk == '0);
        end else begin
          state_n = APPLY;
          idx_n   = idx + 1'b1;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_comparador_bist.sv
// tb_comparador_bist: scoreboard bench driving comparador_bist against several comparator models.
`default_nettype none

module tb_comparador_bist;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 1;
  localparam int NVEC   = 1 << (2 * WIDTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A_out, B_out;
  logic             q_in;
  logic             busy, done, pass;
  logic [2*WIDTH:0] err_count;

  int mode = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int err;
    int pass;
    int a;
    int b;
    int cycles;
  } exp_t;

  exp_t sb[$];

  comparador_bist #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A_out     (A_out),
    .B_out     (B_out),
    .q_in      (q_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // 0 correct, 1 stuck-at-0, 2 inverted, 3 wrong only at A=5,B=5
  function automatic logic model(input int m, input int a, input int b);
    case (m)
      1:       return 1'b0;
      2:       return (a != b);
      3:       return (a == 5 && b == 5) ? 1'b0 : (a == b);
      default: return (a == b);
    endcase
  endfunction

  always_comb q_in = model(mode, int'(A_out), int'(B_out));

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t predict(input int m);
    exp_t e;
    int n = 0;
    int last = NVEC - 1;
    for (int i = 0; i < NVEC; i++) begin
      int a = i / (1 << WIDTH);
      int b = i % (1 << WIDTH);
      if (model(m, a, b) != (a == b)) begin
        n++;
`ifdef STOP_ON_FAIL_EN
        last = i;
        break;
`endif
      end
    end
    e.err    = n;
    e.pass   = (n == 0) ? 1 : 0;
    e.a      = last / (1 << WIDTH);
    e.b      = last % (1 << WIDTH);
    e.cycles = (last + 1) * (SETTLE + 1);
    return e;
  endfunction

  task automatic run(input int m, input bit hold_start, input bit pulse_mid);
    exp_t e;
    int cycles;
    mode = m;
    sb.push_back(predict(m));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = hold_start;
    check("start_busy", int'(busy), 1);
    check("start_clears_done", int'(done), 0);
    check("start_clears_err", int'(err_count), 0);
    cycles = 0;
    while (busy === 1'b1 && cycles < 4 * NVEC * (SETTLE + 1)) begin
      cycles++;
      if (pulse_mid) start = (cycles == 100);
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    check("busy_cycles", cycles, e.cycles);
    check("done", int'(done), 1);
    check("pass", int'(pass), e.pass);
    check("err_count", int'(err_count), e.err);
    check("a_final", int'(A_out), e.a);
    check("b_final", int'(B_out), e.b);
    repeat (3) @(negedge clk);
    check("done_hold", int'(done), 1);
    check("err_hold", int'(err_count), e.err);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_a", int'(A_out), 0);
    check("rst_b", int'(B_out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    run(0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0);
    run(0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a run.
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(err_count), 0);
    check("midrst_a", int'(A_out), 0);
    check("midrst_b", int'(B_out), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", int'(busy), 0);
    run(0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
